// File: rtl/shift_reg_univ.sv
// Universal shift register with single-step ops and a counted burst-shift engine.
// A START with a shift op repeats that op AMT times, reporting BUSY/DONE.
//
// state | meaning
// IDLE  | ops applied once per enabled edge; START with a shift op arms a burst
// SHIFT | latched op applied once per enabled edge until the counter expires
module shift_reg_univ #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       op_r, op_r_nx;
    logic             done_nx;

    function automatic logic is_shift(input logic [2:0] o);
        return (o == OP_SHR) || (o == OP_SHL) || (o == OP_ROR) ||
               (o == OP_ROL) || (o == OP_ASR);
    endfunction

    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] cur,
        input logic             fill_l,
        input logic             fill_r,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (o)
            OP_HOLD: res = cur;
            OP_SHR:  res = {fill_r, cur[WIDTH-1:1]};
            OP_SHL:  res = {cur[WIDTH-2:0], fill_l};
            OP_LOAD: res = ld;
            OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_CLR:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            op_r  <= OP_HOLD;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            cnt   <= cnt_nx;
            op_r  <= op_r_nx;
            done  <= done_nx;
        end
    end

    // DONE is a single-cycle pulse even if EN drops right after the final step.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        cnt_nx   = cnt;
        op_r_nx  = op_r;
        done_nx  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start && is_shift(op)) begin
                        if (amt != '0) begin
                            op_r_nx  = op;
                            cnt_nx   = amt;
                            state_nx = SHIFT;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end else begin
                        q_nx = step(op, q, sl, sr, d);
                    end
                end
                SHIFT: begin
                    // Serial fill bits are taken live on every step of the burst.
                    q_nx   = step(op_r, q, sl, sr, d);
                    cnt_nx = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign so_l = q[WIDTH-1];
    assign so_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an arithmetic reference model.
module tb_shift_reg_univ;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        sl = 1'b0;
    logic        sr = 1'b0;
    logic [31:0] d = '0;
    logic        start = 1'b0;
    logic [5:0]  amt = '0;
    logic [31:0] q;
    logic        so_l, so_r, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    shift_reg_univ #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .sl(sl), .sr(sr), .d(d),
        .start(start), .amt(amt), .q(q), .so_l(so_l), .so_r(so_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register value plus "burst remaining" bookkeeping.
    logic [31:0] m_q = '0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [2:0]  m_op = 3'b000;

    function automatic bit m_is_shift(input logic [2:0] o);
        return o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd5 || o == 3'd6;
    endfunction

    function automatic logic [31:0] m_apply(input logic [2:0] o, input logic [31:0] v);
        case (o)
            3'd1:    return (v >> 1) | (32'(sr) << 31);
            3'd2:    return (v << 1) | 32'(sl);
            3'd3:    return d;
            3'd4:    return (v >> 1) | (v << 31);
            3'd5:    return (v << 1) | (v >> 31);
            3'd6:    return 32'($signed(v) >>> 1);
            3'd7:    return 32'd0;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q = '0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (en) begin
                if (m_busy) begin
                    m_q = m_apply(m_op, m_q);
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end else if (start && m_is_shift(op)) begin
                    if (amt == 0) m_done = 1;
                    else begin
                        m_busy = 1; m_left = int'(amt); m_op = op;
                    end
                end else begin
                    m_q = m_apply(op, m_q);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model q", q, m_q);
            check("model so_l", 32'(so_l), 32'(m_q[31]));
            check("model so_r", 32'(so_r), 32'(m_q[0]));
            check("model busy", 32'(busy), 32'(m_busy));
            check("model done", 32'(done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the START edge; counts BUSY/DONE samples over a fixed window.
    task automatic run_burst(input string nm, input int stall_at, input bit inject,
                             input int exp_busy, input logic [31:0] exp_q);
        int nbusy = 0;
        int ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                check({nm, " q at done"}, q, exp_q);
            end
            en = !(stall_at >= 0 && (i == stall_at || i == stall_at + 1));
            if (inject && i == 1) begin
                start = 1; op = 3'b011; d = 32'h0;
            end else begin
                start = 0; op = 3'b000;
            end
            tick();
        end
        en = 1;
        check({nm, " busy cycles"}, 32'(nbusy), 32'(exp_busy));
        check({nm, " done pulses"}, 32'(ndone), 32'd1);
        check({nm, " final q"}, q, exp_q);
    endtask

    initial begin
        #1 rst = 0;
        chk_on = 1;
        #20;
        @(posedge clk); #1 rst = 1;
        en = 1;

        // Asynchronous reset mid-cycle
        op = 3'b011; d = 32'hFFFF_FFFF; tick();
        check("load ones", q, 32'hFFFF_FFFF);
        op = 3'b000;
        #2 rst = 0;
        #1;
        check("async rst q", q, 32'h0);
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst done", 32'(done), 32'h0);
        tick();
        rst = 1;

        // Load then arithmetic right
        op = 3'b011; d = 32'h8000_0001; tick();
        op = 3'b110; tick();
        op = 3'b000;
        check("asr q", q, 32'hC000_0000);
        check("asr so_l", 32'(so_l), 32'h1);
        check("asr so_r", 32'(so_r), 32'h0);

        // Rotate-left burst of 4
        op = 3'b011; d = 32'h1234_5678; tick();
        op = 3'b101; amt = 6'd4; start = 1; tick();
        check("rol start edge q", q, 32'h1234_5678);
        run_burst("rol4", -1, 0, 4, 32'h2345_6781);

        // Logical right burst of 8 with SR=1, two stall cycles, dropped START
        op = 3'b111; tick();
        sr = 1; op = 3'b001; amt = 6'd8; start = 1; tick();
        run_burst("shr8", 3, 1, 10, 32'hFF00_0000);
        sr = 0;

        // AMT=0 burst, then immediate load with START
        op = 3'b010; amt = 6'd0; start = 1; tick();
        check("amt0 done", 32'(done), 32'h1);
        check("amt0 busy", 32'(busy), 32'h0);
        check("amt0 q", q, 32'hFF00_0000);
        start = 0; op = 3'b000; tick();
        check("amt0 done clears", 32'(done), 32'h0);
        op = 3'b011; d = 32'hA5A5_5A5A; start = 1; amt = 6'd5; tick();
        check("start load q", q, 32'hA5A5_5A5A);
        check("start load done", 32'(done), 32'h0);
        check("start load busy", 32'(busy), 32'h0);
        start = 0; op = 3'b000;

        // Reset aborts a rotate-right burst
        op = 3'b100; amt = 6'd20; start = 1; tick();
        start = 0; op = 3'b000;
        for (int i = 0; i < 5; i++) tick();
        check("ror mid busy", 32'(busy), 32'h1);
        #2 rst = 0;
        #1;
        check("abort q", q, 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        tick();
        check("abort no done", 32'(done), 32'h0);
        rst = 1;
        op = 3'b011; d = 32'h0F0F_0F0F; tick();
        check("post reset load", q, 32'h0F0F_0F0F);
        op = 3'b000;

        // Randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom % 5) != 0;
            op    = 3'($urandom);
            sl    = 1'($urandom);
            sr    = 1'($urandom);
            d     = $urandom;
            start = ($urandom % 6) == 0;
            amt   = 6'($urandom_range(0, 40));
            rst   = ($urandom % 400) != 0;
            tick();
        end
        rst = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register. Next generation of the team's 32-bit load/shift-left/shift-right/hold register.
- Adds rotate, arithmetic shift and clear operations.
- Adds a counted burst-shift engine: one START performs AMT single-bit shifts, with BUSY/DONE handshake.
- Used in datapath serialisers, normalisers and barrel-shift-free multiply/divide sequencing.

Parameters:
- WIDTH, 32, register width in bits (>=2).
- CNT_W, 6, width of AMT and the internal burst counter; must hold WIDTH.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-low reset.
- EN  in  1  cycle enable; 0 freezes Q and burst counter.
- OP  in  3  operation select (see Behaviour).
- SL  in  1  serial fill bit for left shifts (enters Q[0]).
- SR  in  1  serial fill bit for logical right shifts (enters Q[WIDTH-1]).
- D  in  WIDTH  parallel load data.
- START  in  1  begin burst of OP repeated AMT times.
- AMT  in  CNT_W  burst length in single-bit steps.
- Q  out  WIDTH  register contents.
- SO_L  out  1  Q[WIDTH-1] (combinational from Q).
- SO_R  out  1  Q[0] (combinational from Q).
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse when a burst finishes.

Behaviour:
- Reset (RST=0, asynchronous): Q=0, state=IDLE, counter=0, BUSY=0, DONE=0. Takes effect immediately and holds while RST=0. Deassertion is sampled on the next CLK edge.
- OP encoding, single step:
  - 000: hold.
  - 001: logical right, Q <= {SR, Q[W-1:1]}.
  - 010: left, Q <= {Q[W-2:0], SL}.
  - 011: load, Q <= D.
  - 100: rotate right, Q <= {Q[0], Q[W-1:1]}.
  - 101: rotate left, Q <= {Q[W-2:0], Q[W-1]}.
  - 110: arithmetic right, Q <= {Q[W-1], Q[W-1:1]}.
  - 111: clear, Q <= 0.
  - "Shift ops" means 001, 010, 100, 101, 110.
- State IDLE:
  - EN=0: everything holds.
  - EN=1, START=0: OP applied once at the clock edge. Latency 1 cycle.
  - EN=1, START=1, shift op, AMT>0: latch OP into op_r; counter <= AMT; go to SHIFT. Q is not modified on the START edge.
  - EN=1, START=1, shift op, AMT=0: no shift; DONE=1 on the next cycle; stay IDLE; BUSY stays 0.
  - EN=1, START=1, non-shift op (000/011/111): executed as an immediate op. No BUSY, no DONE.
- State SHIFT (BUSY=1):
  - Each cycle with EN=1: apply op_r once; counter decrements.
  - When counter==1 at the edge: perform the final step, go to IDLE, DONE registered to 1 for exactly one cycle. DONE is concurrent with the final Q value.
  - Burst of AMT=N takes N+1 edges from the START edge to the final Q. BUSY is high for N cycles.
  - EN=0 stalls: Q, counter and state hold; BUSY stays 1.
  - OP, D, START and AMT are ignored while BUSY. A START during BUSY is dropped, not queued.
  - SL/SR are sampled live every step, so serial data may change per bit.
- AMT >= WIDTH is legal: shifts saturate naturally to all-fill or all-sign; rotates wrap, so AMT=WIDTH returns the original value.
- A new START is accepted in the same cycle DONE is high, because the state is already IDLE.
- Reset mid-burst: immediate abort to reset values. No DONE pulse.

Test Plan (WIDTH=32):
- Pulse RST=0 mid-cycle with Q=0xFFFF_FFFF -> Q=0, BUSY=0, DONE=0 before the next CLK edge.
- Load D=0x8000_0001 (OP=011), then one OP=110 -> Q=0xC000_0000; SO_L=1, SO_R=0.
- Q=0x1234_5678, START, OP=101, AMT=4 -> BUSY high 4 cycles; final Q=0x2345_6781; DONE high exactly 1 cycle, aligned with final Q.
- Q=0, START, OP=001, AMT=8, SR=1, EN=0 for 2 cycles mid-burst -> Q=0xFF00_0000; BUSY high 10 cycles; a START issued during BUSY has no effect.
- START, OP=010, AMT=0 -> DONE pulse next cycle; Q unchanged; BUSY never asserts. Then START, OP=011 -> immediate load, no DONE.
- Burst OP=100, AMT=20, RST=0 after 5 steps -> Q=0, BUSY=0, no DONE. After release, immediate OP=011 works on the first edge.
